// File: rtl/serial_comparator_param_if.sv
// Operand/result bundle for the digit-serial magnitude comparator.
// The master drives the digit stream and modes; the slave returns the running verdict.
interface serial_comparator_param_if #(
  parameter int DIG = 1
);
  logic           start;
  logic           signed_mode;
  logic           lsb_first;
  logic           in_valid;
  logic [DIG-1:0] x;
  logic [DIG-1:0] y;
  logic           gt;
  logic           lt;
  logic           eq;
  logic           busy;
  logic           done;

  modport master (
    output start, signed_mode, lsb_first, in_valid, x, y,
    input  gt, lt, eq, busy, done
  );

  modport slave (
    input  start, signed_mode, lsb_first, in_valid, x, y,
    output gt, lt, eq, busy, done
  );
endinterface

// File: rtl/serial_comparator_param.sv
// Digit-serial comparator: consumes WIDTH-bit operands DIG bits per accepted beat,
// MSB- or LSB-digit first, unsigned or two's-complement, keeping a running gt/lt verdict.
module serial_comparator_param #(
  parameter int WIDTH = 8,
  parameter int DIG   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  serial_comparator_param_if.slave  bus
);

  localparam int NDIG = WIDTH / DIG;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           sm_q;
  logic           lsb_q;
  logic           gt_q;
  logic           lt_q;
  logic           busy_q;
  logic           done_q;

  logic           is_sign;
  logic [DIG-1:0] xd;
  logic [DIG-1:0] yd;
  logic           dig_gt;
  logic           dig_lt;

  // Flipping the top bit of the sign digit maps two's-complement order onto unsigned order.
  always_comb begin
    is_sign = lsb_q ? (cnt == LAST) : (cnt == '0);
    xd      = bus.x;
    yd      = bus.y;
    if (sm_q && is_sign) begin
      xd[DIG-1] = ~bus.x[DIG-1];
      yd[DIG-1] = ~bus.y[DIG-1];
    end
    dig_gt = (xd > yd);
    dig_lt = (xd < yd);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      sm_q   <= 1'b0;
      lsb_q  <= 1'b0;
      gt_q   <= 1'b0;
      lt_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (bus.start) begin
      state  <= RUN;
      cnt    <= '0;
      sm_q   <= bus.signed_mode;
      lsb_q  <= bus.lsb_first;
      gt_q   <= 1'b0;
      lt_q   <= 1'b0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.in_valid) begin
            cnt <= cnt + CW'(1);
            // MSB-first: first differing digit decides; LSB-first: last differing digit decides.
            if (lsb_q) begin
              if (dig_gt) begin
                gt_q <= 1'b1;
                lt_q <= 1'b0;
              end else if (dig_lt) begin
                gt_q <= 1'b0;
                lt_q <= 1'b1;
              end
            end else if (!gt_q && !lt_q) begin
              gt_q <= dig_gt;
              lt_q <= dig_lt;
            end
            if (cnt == LAST) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gt   = gt_q;
  assign bus.lt   = lt_q;
  assign bus.eq   = ~gt_q & ~lt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_serial_comparator_param.sv
// Self-checking bench: two comparator instances (1-bit and 4-bit digits) checked every
// cycle against an operand-level reference model, plus directed literal expectations.
module tb_serial_comparator_param;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  serial_comparator_param_if #(.DIG(1)) bus1();
  serial_comparator_param_if #(.DIG(4)) bus4();

  serial_comparator_param #(.WIDTH(8), .DIG(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  serial_comparator_param #(.WIDTH(8), .DIG(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  int         errors = 0;
  int         checks = 0;
  bit         cmp_en = 1'b0;

  int         m_phase [2] = '{P_IDLE, P_IDLE};
  int         m_k     [2] = '{0, 0};
  logic       m_sm    [2] = '{1'b0, 1'b0};
  logic       m_lsb   [2] = '{1'b0, 1'b0};
  logic [7:0] m_x     [2] = '{8'h00, 8'h00};
  logic [7:0] m_y     [2] = '{8'h00, 8'h00};
  logic [7:0] pend_x  [2] = '{8'h00, 8'h00};
  logic [7:0] pend_y  [2] = '{8'h00, 8'h00};

  function automatic int dig_of(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int ndig_of(int d);
    return 8 / dig_of(d);
  endfunction

  // Verdict after k digits: MSB-first compares the top k digits as a (signed) prefix,
  // LSB-first compares the low k digits unsigned until the sign digit completes the word.
  function automatic logic [1:0] ref_cmp(logic [7:0] x, logic [7:0] y, logic sm,
                                         logic lsb, int k, int dg);
    int nd;
    int xs;
    int ys;
    nd = 8 / dg;
    if (k == 0) return 2'b00;
    if (!lsb || k == nd) begin
      xs = sm ? int'($signed(x)) : int'(x);
      ys = sm ? int'($signed(y)) : int'(y);
      if (!lsb) begin
        xs = xs >>> (8 - k * dg);
        ys = ys >>> (8 - k * dg);
      end
    end else begin
      xs = int'(x) % (1 << (k * dg));
      ys = int'(y) % (1 << (k * dg));
    end
    return {xs > ys, xs < ys};
  endfunction

  function automatic logic [4:0] model_out(int d);
    logic [1:0] r;
    r = ref_cmp(m_x[d], m_y[d], m_sm[d], m_lsb[d], m_k[d], dig_of(d));
    return {r[1], r[0], ~r[1] & ~r[0], m_phase[d] == P_RUN, m_phase[d] == P_DONE};
  endfunction

  task automatic model_step(int d, logic st, logic sm, logic lsb, logic v);
    if (st) begin
      m_phase[d] = P_RUN;
      m_k[d]     = 0;
      m_sm[d]    = sm;
      m_lsb[d]   = lsb;
      m_x[d]     = pend_x[d];
      m_y[d]     = pend_y[d];
    end else if (m_phase[d] == P_RUN) begin
      if (v) begin
        m_k[d] = m_k[d] + 1;
        if (m_k[d] == ndig_of(d)) m_phase[d] = P_DONE;
      end
    end else if (m_phase[d] == P_DONE) begin
      m_phase[d] = P_IDLE;
    end
  endtask

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      model_step(0, bus1.start, bus1.signed_mode, bus1.lsb_first, bus1.in_valid);
      model_step(1, bus4.start, bus4.signed_mode, bus4.lsb_first, bus4.in_valid);
    end
  end

  always @(negedge reset) begin
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = P_IDLE;
      m_k[d]     = 0;
      m_sm[d]    = 1'b0;
      m_lsb[d]   = 1'b0;
    end
  end

  task automatic check_output(string name, logic [4:0] act, logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got {gt,lt,eq,busy,done}=%b, expected %b",
               name, $time, act, exp);
    end
  endtask

  function automatic logic [4:0] dut_vec(int d);
    if (d == 0) return {bus1.gt, bus1.lt, bus1.eq, bus1.busy, bus1.done};
    return {bus4.gt, bus4.lt, bus4.eq, bus4.busy, bus4.done};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("cycle_dig1", dut_vec(0), model_out(0));
      check_output("cycle_dig4", dut_vec(1), model_out(1));
    end
  end

  task automatic set_idle();
    bus1.start = 1'b0; bus1.signed_mode = 1'b0; bus1.lsb_first = 1'b0;
    bus1.in_valid = 1'b0; bus1.x = 1'b0; bus1.y = 1'b0;
    bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.lsb_first = 1'b0;
    bus4.in_valid = 1'b0; bus4.x = 4'h0; bus4.y = 4'h0;
  endtask

  task automatic drive_cycle(int d, logic st, logic sm, logic lsb, logic v,
                             logic [3:0] xd, logic [3:0] yd);
    set_idle();
    if (d == 0) begin
      bus1.start = st; bus1.signed_mode = sm; bus1.lsb_first = lsb;
      bus1.in_valid = v; bus1.x = xd[0]; bus1.y = yd[0];
    end else begin
      bus4.start = st; bus4.signed_mode = sm; bus4.lsb_first = lsb;
      bus4.in_valid = v; bus4.x = xd; bus4.y = yd;
    end
    @(posedge clk);
    #1;
  endtask

  // Start (with junk digits that must be ignored), then n_dig digits with optional stalls.
  task automatic apply_stimulus(int d, logic [7:0] xv, logic [7:0] yv, logic sm, logic lsb,
                                int stall_pct, int n_dig);
    int dg;
    int sh;
    int mask;
    dg   = dig_of(d);
    mask = (1 << dg) - 1;
    pend_x[d] = xv;
    pend_y[d] = yv;
    drive_cycle(d, 1'b1, sm, lsb, 1'b1, 4'($urandom), 4'($urandom));
    for (int i = 0; i < n_dig; i++) begin
      for (int s = 0; s < 4 && $urandom_range(99) < stall_pct; s++)
        drive_cycle(d, 1'b0, ~sm, ~lsb, 1'b0, 4'($urandom), 4'($urandom));
      sh = lsb ? i * dg : 8 - (i + 1) * dg;
      drive_cycle(d, 1'b0, ~sm, ~lsb, 1'b1, 4'(int'(xv >> sh) & mask),
                  4'(int'(yv >> sh) & mask));
    end
  endtask

  typedef struct {
    logic [7:0] xv;
    logic [7:0] yv;
    logic       sm;
    logic       lsb;
    logic [1:0] res;
  } vec_t;

  vec_t table_v [5] = '{
    '{8'h7F, 8'h80, 1'b1, 1'b0, 2'b10},
    '{8'h7F, 8'h80, 1'b0, 1'b1, 2'b01},
    '{8'hFE, 8'hFF, 1'b1, 1'b1, 2'b01},
    '{8'h00, 8'h00, 1'b1, 1'b0, 2'b00},
    '{8'h81, 8'h01, 1'b1, 1'b1, 2'b01}
  };

  initial begin
    set_idle();
    #1 reset = 1'b0;
    #2;
    cmp_en = 1'b1;
    check_output("reset_dig1", dut_vec(0), 5'b00100);
    check_output("reset_dig4", dut_vec(1), 5'b00100);

    check_output("pin_a5a3_d5", {3'b000, ref_cmp(8'hA5, 8'hA3, 1'b0, 1'b0, 5, 1)}, 5'b00000);
    check_output("pin_a5a3_d6", {3'b000, ref_cmp(8'hA5, 8'hA3, 1'b0, 1'b0, 6, 1)}, 5'b00010);
    check_output("pin_807f_s",  {3'b000, ref_cmp(8'h80, 8'h7F, 1'b1, 1'b0, 1, 4)}, 5'b00001);
    check_output("pin_807f_u",  {3'b000, ref_cmp(8'h80, 8'h7F, 1'b0, 1'b0, 1, 4)}, 5'b00010);
    check_output("pin_0102_d1", {3'b000, ref_cmp(8'h01, 8'h02, 1'b0, 1'b1, 1, 1)}, 5'b00010);
    check_output("pin_0102_d2", {3'b000, ref_cmp(8'h01, 8'h02, 1'b0, 1'b1, 2, 1)}, 5'b00001);
    check_output("pin_ff01_s",  {3'b000, ref_cmp(8'hFF, 8'h01, 1'b1, 1'b1, 8, 1)}, 5'b00001);

    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;

    apply_stimulus(0, 8'hA5, 8'hA3, 1'b0, 1'b0, 0, 8);
    check_output("a5a3_done", dut_vec(0), 5'b10001);
    drive_cycle(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    check_output("a5a3_idle", dut_vec(0), 5'b10000);

    apply_stimulus(1, 8'h80, 8'h7F, 1'b1, 1'b0, 0, 2);
    check_output("807f_signed", dut_vec(1), 5'b01001);
    apply_stimulus(1, 8'h80, 8'h7F, 1'b0, 1'b0, 0, 2);
    check_output("807f_unsigned", dut_vec(1), 5'b10001);

    apply_stimulus(0, 8'h01, 8'h02, 1'b0, 1'b1, 0, 8);
    check_output("0102_lsb", dut_vec(0), 5'b01001);
    apply_stimulus(0, 8'hFF, 8'h01, 1'b1, 1'b1, 0, 8);
    check_output("ff01_lsb_signed", dut_vec(0), 5'b01001);
    for (int i = 0; i < 4; i++)
      drive_cycle(0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 4'h0);
    check_output("idle_valid_ignored", dut_vec(0), 5'b01000);

    apply_stimulus(0, 8'h3C, 8'h3C, 1'b0, 1'b0, 40, 8);
    check_output("3c_stalled", dut_vec(0), 5'b00101);

    apply_stimulus(0, 8'hF0, 8'h0F, 1'b0, 1'b0, 0, 3);
    check_output("abort_mid", dut_vec(0), 5'b10010);
    apply_stimulus(0, 8'h12, 8'h34, 1'b0, 1'b0, 20, 8);
    check_output("after_abort", dut_vec(0), 5'b01001);

    apply_stimulus(0, 8'h55, 8'h50, 1'b0, 1'b0, 0, 4);
    #2 reset = 1'b0;
    #1;
    check_output("midrun_reset_dig1", dut_vec(0), 5'b00100);
    check_output("midrun_reset_dig4", dut_vec(1), 5'b00100);
    set_idle();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_output("release_no_change", dut_vec(0), 5'b00100);
    apply_stimulus(0, 8'h55, 8'h50, 1'b0, 1'b0, 0, 8);
    check_output("after_reset_run", dut_vec(0), 5'b10001);

    foreach (table_v[i]) begin
      for (int d = 0; d < 2; d++) begin
        apply_stimulus(d, table_v[i].xv, table_v[i].yv, table_v[i].sm, table_v[i].lsb,
                       25, ndig_of(d));
        check_output($sformatf("table%0d_dut%0d", i, d), dut_vec(d),
                     {table_v[i].res, ~table_v[i].res[1] & ~table_v[i].res[0], 2'b01});
      end
    end

    drive_cycle(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    drive_cycle(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
